bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared single-bit tri-state bus that feeds the LED output stage.
- Grants bus ownership to one of NUM_REQ requesters at a time and drives that owner's tri-state output enable.
- Produces the bus-enable and one-hot decode result consumed by the LED stage.
- Inserts one dead turnaround cycle between owners so two drivers never overlap.

---
 rtl/bus_arbiter_if.sv | 34 +++
 rtl/bus_arbiter.sv | 128 ++++++++++++
 tb/tb_bus_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbiter interface: request lines in, ownership/LED-stage signals out.
// The master modport is the arbiter side, the slave modport the requester/LED side.
interface bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] owner_oe;
  logic               bus_en;
  logic [NUM_REQ-1:0] decode;
  logic [ID_W-1:0]    owner_id;
  logic               busy;
  logic               timeout_pulse;

  modport master (
    input  req,
    output owner_oe,
    output bus_en,
    output decode,
    output owner_id,
    output busy,
    output timeout_pulse
  );

  modport slave (
    output req,
    input  owner_oe,
    input  bus_en,
    input  decode,
    input  owner_id,
    input  busy,
    input  timeout_pulse
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared tri-state LED bus with one dead turnaround cycle.
// Optional forced release after MAX_HOLD grant cycles when ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  if ((2 ** CNT_W) <= MAX_HOLD) begin : g_bad_cnt_w
    $error("CNT_W too narrow for MAX_HOLD");
  end

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] owner_oe_q;
  logic [NUM_REQ-1:0] decode_q;
  logic               bus_en_q;
  logic [ID_W-1:0]    owner_id_q;
  logic               busy_q;
  logic               timeout_q;

  logic [NUM_REQ-1:0] req;
  logic               any_req;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    idx;
  logic               found;
  logic [NUM_REQ-1:0] winner_oh;
  logic               owner_req;
  logic               hold_expired;
  logic [ID_W-1:0]    ptr_after_owner;

  assign req     = bus.req;
  assign any_req = |req;

  // First set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    winner = ptr_q;
    idx    = ptr_q;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign winner_oh       = NUM_REQ'(1) << winner;
  assign owner_req       = req[owner_id_q];
  assign ptr_after_owner = ID_W'((32'(owner_id_q) + 1) % NUM_REQ);

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);
  assign hold_expired = (cnt_q == HoldLast);
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      cnt_q      <= '0;
      owner_oe_q <= '0;
      decode_q   <= '0;
      bus_en_q   <= 1'b0;
      owner_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        StIdle, StTurn: begin
          if (any_req) begin
            state_q    <= StGrant;
            owner_oe_q <= winner_oh;
            decode_q   <= winner_oh;
            owner_id_q <= winner;
            bus_en_q   <= 1'b1;
            busy_q     <= 1'b1;
            cnt_q      <= '0;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StGrant: begin
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
          // A forced release is only distinguishable from a normal one while req is still up.
          if (!owner_req || hold_expired) begin
            state_q    <= StTurn;
            owner_oe_q <= '0;
            decode_q   <= '0;
            bus_en_q   <= 1'b0;
            ptr_q      <= ptr_after_owner;
            timeout_q  <= owner_req;
          end
        end
        default: begin
          state_q    <= StIdle;
          owner_oe_q <= '0;
          decode_q   <= '0;
          bus_en_q   <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.owner_oe      = owner_oe_q;
  assign bus.decode        = decode_q;
  assign bus.bus_en        = bus_en_q;
  assign bus.owner_id      = owner_id_q;
  assign bus.busy          = busy_q;
  assign bus.timeout_pulse = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: expected outputs are queued when a
// cycle's stimulus is driven and checked just after the following rising edge.
module tb_bus_arbiter;

  logic clk;
  logic rst;

  bus_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  bus_arbiter #(
    .NUM_REQ (4),
    .ID_W    (2),
    .MAX_HOLD(15),
    .CNT_W   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] oe;
    logic       en;
    logic [1:0] id;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // own < 0 means no owner on the bus this cycle.
  task automatic step(input string tag, input logic r_rst, input logic [3:0] r,
                      input int own, input int id, input logic bz, input logic to);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst     = r_rst;
    bus.req = r;
    e.tag   = tag;
    e.oe    = (own >= 0) ? 4'(1 << own) : 4'b0000;
    e.en    = (own >= 0);
    e.id    = 2'(id);
    e.busy  = bz;
    e.to    = to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    assert (sb.size() > 0)
    else begin
      n_fail++;
      $error("FAIL %s: scoreboard empty observed 0 expected 1", tag);
    end
    if (sb.size() > 0) begin
      g = sb.pop_front();
      chk({g.tag, ".owner_oe"}, 32'(bus.owner_oe), 32'(g.oe));
      chk({g.tag, ".decode"}, 32'(bus.decode), 32'(g.oe));
      chk({g.tag, ".bus_en"}, 32'(bus.bus_en), 32'(g.en));
      chk({g.tag, ".owner_id"}, 32'(bus.owner_id), 32'(g.id));
      chk({g.tag, ".busy"}, 32'(bus.busy), 32'(g.busy));
      chk({g.tag, ".timeout"}, 32'(bus.timeout_pulse), 32'(g.to));
    end
  endtask

  initial begin
    rst     = 1'b1;
    bus.req = 4'b0000;

    // Reset and idle
    step("rst0", 1'b1, 4'b0000, -1, 0, 1'b0, 1'b0);
    step("rst1", 1'b1, 4'b0000, -1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 4'b0000, -1, 0, 1'b0, 1'b0);

    // Single requester 2, held three cycles
    step("g2a", 1'b0, 4'b0100, 2, 2, 1'b1, 1'b0);
    step("g2b", 1'b0, 4'b0100, 2, 2, 1'b1, 1'b0);
    step("g2c", 1'b0, 4'b0100, 2, 2, 1'b1, 1'b0);
    step("t2", 1'b0, 4'b0000, -1, 2, 1'b1, 1'b0);
    step("i2", 1'b0, 4'b0000, -1, 2, 1'b0, 1'b0);

    // ptr = 3: requester 3 first, then wrap to 0 directly from TURN
    step("w3a", 1'b0, 4'b1001, 3, 3, 1'b1, 1'b0);
    step("w3b", 1'b0, 4'b1001, 3, 3, 1'b1, 1'b0);
    step("wt3", 1'b0, 4'b0001, -1, 3, 1'b1, 1'b0);
    step("w0a", 1'b0, 4'b0001, 0, 0, 1'b1, 1'b0);
    step("w0b", 1'b0, 4'b0001, 0, 0, 1'b1, 1'b0);
    step("wt0", 1'b0, 4'b0000, -1, 0, 1'b1, 1'b0);
    step("wi0", 1'b0, 4'b0000, -1, 0, 1'b0, 1'b0);

    // ptr = 1: non-owner req changes ignored during GRANT
    step("n2a", 1'b0, 4'b0100, 2, 2, 1'b1, 1'b0);
    step("n2b", 1'b0, 4'b0101, 2, 2, 1'b1, 1'b0);
    step("n2c", 1'b0, 4'b1111, 2, 2, 1'b1, 1'b0);
    step("nt2", 1'b0, 4'b1011, -1, 2, 1'b1, 1'b0);
    step("n3", 1'b0, 4'b1011, 3, 3, 1'b1, 1'b0);
    step("nt3", 1'b0, 4'b0000, -1, 3, 1'b1, 1'b0);
    step("ni3", 1'b0, 4'b0000, -1, 3, 1'b0, 1'b0);

    // ptr = 0: sole requester drops and re-asserts, re-granted after TURN
    step("s2a", 1'b0, 4'b0100, 2, 2, 1'b1, 1'b0);
    step("st2", 1'b0, 4'b0000, -1, 2, 1'b1, 1'b0);
    step("s2b", 1'b0, 4'b0100, 2, 2, 1'b1, 1'b0);
    step("st2b", 1'b0, 4'b0000, -1, 2, 1'b1, 1'b0);
    step("si2", 1'b0, 4'b0000, -1, 2, 1'b0, 1'b0);

    // Reset, then all four requesting, each owner drops after two cycles
    step("rr_rst", 1'b1, 4'b0000, -1, 0, 1'b0, 1'b0);
    step("rr0a", 1'b0, 4'b1111, 0, 0, 1'b1, 1'b0);
    step("rr0b", 1'b0, 4'b1111, 0, 0, 1'b1, 1'b0);
    step("rrt0", 1'b0, 4'b1110, -1, 0, 1'b1, 1'b0);
    step("rr1a", 1'b0, 4'b1110, 1, 1, 1'b1, 1'b0);
    step("rr1b", 1'b0, 4'b1110, 1, 1, 1'b1, 1'b0);
    step("rrt1", 1'b0, 4'b1100, -1, 1, 1'b1, 1'b0);
    step("rr2a", 1'b0, 4'b1100, 2, 2, 1'b1, 1'b0);
    step("rr2b", 1'b0, 4'b1100, 2, 2, 1'b1, 1'b0);
    step("rrt2", 1'b0, 4'b1000, -1, 2, 1'b1, 1'b0);
    step("rr3a", 1'b0, 4'b1000, 3, 3, 1'b1, 1'b0);
    step("rr3b", 1'b0, 4'b1000, 3, 3, 1'b1, 1'b0);
    step("rrt3", 1'b0, 4'b0111, -1, 3, 1'b1, 1'b0);
    step("rr0c", 1'b0, 4'b0111, 0, 0, 1'b1, 1'b0);
    step("rrt0b", 1'b0, 4'b0000, -1, 0, 1'b1, 1'b0);
    step("rri", 1'b0, 4'b0000, -1, 0, 1'b0, 1'b0);

    // ptr = 1: reset asserted mid-grant of owner 1
    step("m1a", 1'b0, 4'b0010, 1, 1, 1'b1, 1'b0);
    step("m1b", 1'b0, 4'b0010, 1, 1, 1'b1, 1'b0);
    step("mrst", 1'b1, 4'b0010, -1, 0, 1'b0, 1'b0);
    step("m1c", 1'b0, 4'b0010, 1, 1, 1'b1, 1'b0);
    step("mt1", 1'b0, 4'b0000, -1, 1, 1'b1, 1'b0);
    step("mi1", 1'b0, 4'b0000, -1, 1, 1'b0, 1'b0);

    // Move ptr to 3, reset, then prove ptr was cleared to 0
    step("p2", 1'b0, 4'b0100, 2, 2, 1'b1, 1'b0);
    step("pt2", 1'b0, 4'b0000, -1, 2, 1'b1, 1'b0);
    step("pi2", 1'b0, 4'b0000, -1, 2, 1'b0, 1'b0);
    step("prst", 1'b1, 4'b0000, -1, 0, 1'b0, 1'b0);
    step("p0", 1'b0, 4'b1001, 0, 0, 1'b1, 1'b0);
    step("pt0", 1'b0, 4'b0000, -1, 0, 1'b1, 1'b0);
    step("pi0", 1'b0, 4'b0000, -1, 0, 1'b0, 1'b0);

    // Requester 0 held permanently
    step("h_rst", 1'b1, 4'b0000, -1, 0, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 15; k++) step("hold", 1'b0, 4'b0001, 0, 0, 1'b1, 1'b0);
      step("tmo", 1'b0, 4'b0001, -1, 0, 1'b1, 1'b1);
    end
    step("hold_re", 1'b0, 4'b0001, 0, 0, 1'b1, 1'b0);
`else
    for (int k = 0; k < 40; k++) step("hold", 1'b0, 4'b0001, 0, 0, 1'b1, 1'b0);
`endif
    step("ht0", 1'b0, 4'b0000, -1, 0, 1'b1, 1'b0);
    step("hi0", 1'b0, 4'b0000, -1, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
